// File: rtl/sparc_pkg.sv
// Shared SPARC integer-unit types: Bicc cond encodings, branch FSM states,
// the icc flag record and the branch target helper.
package sparc_pkg;

  typedef enum logic [3:0] {
    COND_BN   = 4'b0000,
    COND_BE   = 4'b0001,
    COND_BLE  = 4'b0010,
    COND_BL   = 4'b0011,
    COND_BLEU = 4'b0100,
    COND_BCS  = 4'b0101,
    COND_BNEG = 4'b0110,
    COND_BVS  = 4'b0111,
    COND_BA   = 4'b1000,
    COND_BNE  = 4'b1001,
    COND_BG   = 4'b1010,
    COND_BGE  = 4'b1011,
    COND_BGU  = 4'b1100,
    COND_BCC  = 4'b1101,
    COND_BPOS = 4'b1110,
    COND_BVC  = 4'b1111
  } cond_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DELAY = 1'b1
  } br_state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } icc_t;

  // Word displacement, sign-extended and scaled to bytes; wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [21:0] disp22);
    return pc + {{8{disp22[21]}}, disp22, 2'b00};
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational Bicc condition evaluator: cond[3] inverts the base test
// selected by cond[2:0].
import sparc_pkg::*;

module cond_eval (
  input  logic [3:0] cond,
  input  icc_t       icc,
  output logic       cond_true
);

  logic base;

  always_comb begin
    base = 1'b0;
    case (cond[2:0])
      3'b000: base = 1'b0;
      3'b001: base = icc.z;
      3'b010: base = icc.z | (icc.n ^ icc.v);
      3'b011: base = icc.n ^ icc.v;
      3'b100: base = icc.c | icc.z;
      3'b101: base = icc.c;
      3'b110: base = icc.n;
      3'b111: base = icc.v;
      default: base = 1'b0;
    endcase
  end

  assign cond_true = base ^ cond[3];

endmodule

// File: rtl/icc_branch_unit.sv
// SPARC icc register and Bicc branch/delay-slot control.
// Optional macro ICC_BYPASS_EN: a branch sees flags written in its own cycle.
import sparc_pkg::*;

module icc_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flags_we,
  input  logic        N_in,
  input  logic        Z_in,
  input  logic        C_in,
  input  logic        V_in,
  input  logic        br_valid,
  input  logic [3:0]  cond,
  input  logic        annul,
  input  logic [21:0] disp22,
  input  logic [31:0] pc,
  input  logic        slot_valid,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic        V,
  output logic        taken,
  output logic [31:0] target,
  output logic        squash,
  output logic        dcti_err
);

  icc_t        icc_q, icc_in, icc_eval;
  logic        cond_true;
  br_state_e   state_q, state_d;
  logic        taken_q, taken_d;
  logic [31:0] target_q, target_d;
  logic        annul_q, annul_d;

  always_comb begin
    icc_in = '{n: N_in, z: Z_in, c: C_in, v: V_in};
`ifdef ICC_BYPASS_EN
    icc_eval = flags_we ? icc_in : icc_q;
`else
    icc_eval = icc_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst)
      icc_q <= '0;
    else if (flags_we)
      icc_q <= icc_in;
  end

  cond_eval u_cond_eval (
    .cond      (cond),
    .icc       (icc_eval),
    .cond_true (cond_true)
  );

  always_comb begin
    state_d  = state_q;
    taken_d  = 1'b0;
    target_d = target_q;
    annul_d  = annul_q;
    squash   = 1'b0;
    dcti_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          state_d  = ST_DELAY;
          taken_d  = cond_true;
          target_d = branch_target(pc, disp22);
          annul_d  = annul & (~cond_true | (cond == COND_BA));
        end
      end
      ST_DELAY: begin
        // A branch arriving here is a DCTI couple: it occupies the slot.
        if (slot_valid || br_valid) begin
          squash   = annul_q;
          dcti_err = br_valid;
          state_d  = ST_IDLE;
          annul_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      squash   = 1'b0;
      dcti_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      taken_q  <= 1'b0;
      target_q <= '0;
      annul_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      annul_q  <= annul_d;
    end
  end

  assign N      = icc_q.n;
  assign Z      = icc_q.z;
  assign C      = icc_q.c;
  assign V      = icc_q.v;
  assign taken  = taken_q;
  assign target = target_q;

endmodule

// File: tb/tb_icc_branch_unit.sv
// Directed scoreboard bench for icc_branch_unit; honours ICC_BYPASS_EN.
module tb_icc_branch_unit;

  logic        clk = 1'b0;
  logic        rst, flags_we, N_in, Z_in, C_in, V_in;
  logic        br_valid, annul, slot_valid;
  logic [3:0]  cond;
  logic [21:0] disp22;
  logic [31:0] pc;
  logic        N, Z, C, V, taken, squash, dcti_err;
  logic [31:0] target;

  typedef struct {
    string       tag;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  icc_branch_unit dut (
    .clk(clk), .rst(rst), .flags_we(flags_we),
    .N_in(N_in), .Z_in(Z_in), .C_in(C_in), .V_in(V_in),
    .br_valid(br_valid), .cond(cond), .annul(annul), .disp22(disp22),
    .pc(pc), .slot_valid(slot_valid),
    .N(N), .Z(Z), .C(C), .V(V),
    .taken(taken), .target(target), .squash(squash), .dcti_err(dcti_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [3:0] nzcv);
    flags_we = 1'b1;
    {N_in, Z_in, C_in, V_in} = nzcv;
    tick();
    flags_we = 1'b0;
  endtask

  // Drive one Bicc for a cycle, queue its expected result, check it next cycle.
  task automatic branch(input string tag, input logic [3:0] c, input logic a,
                        input logic [31:0] p, input logic [21:0] d,
                        input logic exp_taken, input logic [31:0] exp_target);
    br_valid = 1'b1;
    cond = c;
    annul = a;
    pc = p;
    disp22 = d;
    sb.push_back('{tag: tag, taken: exp_taken, target: exp_target});
    tick();
    br_valid = 1'b0;
    flags_we = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_taken"}, {31'd0, taken}, {31'd0, e.taken});
      if (e.taken)
        chk({e.tag, "_target"}, target, e.target);
    end
  endtask

  // Present the delay-slot instruction and check squash in that cycle.
  task automatic slot(input string tag, input logic exp_squash);
    slot_valid = 1'b1;
    #1;
    chk({tag, "_squash"}, {31'd0, squash}, {31'd0, exp_squash});
    tick();
    slot_valid = 1'b0;
    chk({tag, "_taken_pulse"}, {31'd0, taken}, 32'd0);
  endtask

  initial begin
    logic exp_byp;
    rst = 1'b1; flags_we = 1'b1; {N_in, Z_in, C_in, V_in} = 4'b1111;
    br_valid = 1'b1; cond = 4'b1000; annul = 1'b1; disp22 = '0; pc = '0;
    slot_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0; flags_we = 1'b0; br_valid = 1'b0; annul = 1'b0;
    chk("rst_icc", {28'd0, N, Z, C, V}, 32'd0);
    chk("rst_taken", {31'd0, taken}, 32'd0);
    chk("rst_target", target, 32'd0);
    #1;
    chk("rst_squash", {31'd0, squash}, 32'd0);
    chk("rst_dcti", {31'd0, dcti_err}, 32'd0);

    // BE taken with Z set
    set_flags(4'b0100);
    chk("flags_0100", {28'd0, N, Z, C, V}, 32'h4);
    branch("be", 4'b0001, 1'b0, 32'h100, 22'd4, 1'b1, 32'h110);
    slot("be", 1'b0);

    // BGE with N=1,V=0 not taken, annulled slot
    set_flags(4'b1000);
    chk("flags_1000", {28'd0, N, Z, C, V}, 32'h8);
    branch("bge", 4'b1011, 1'b1, 32'h300, 22'd8, 1'b0, 32'h0);
    slot("bge", 1'b1);

    // BA,a with negative displacement wrapping below zero
    branch("ba_wrap", 4'b1000, 1'b1, 32'h0, 22'h3FFFFF, 1'b1, 32'hFFFFFFFC);
    slot("ba_wrap", 1'b1);

    // Flag write and BE in the same cycle, prior Z=0
`ifdef ICC_BYPASS_EN
    exp_byp = 1'b1;
`else
    exp_byp = 1'b0;
`endif
    flags_we = 1'b1;
    {N_in, Z_in, C_in, V_in} = 4'b0100;
    branch("bypass", 4'b0001, 1'b0, 32'h40, 22'd2, exp_byp, 32'h48);
    chk("flags_bypass", {28'd0, N, Z, C, V}, 32'h4);
    slot("bypass", 1'b0);

    // BNE with Z=1 not taken, annulled; slot arrives 3 cycles late
    branch("bne_late", 4'b1001, 1'b1, 32'h500, 22'd1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("late_wait_squash", {31'd0, squash}, 32'd0);
      tick();
      chk("late_wait_taken", {31'd0, taken}, 32'd0);
    end
    slot("bne_late", 1'b1);

    // DCTI couple: branch in the delay slot of a taken BA
    branch("dcti_first", 4'b1000, 1'b0, 32'h200, 22'd1, 1'b1, 32'h204);
    br_valid = 1'b1; cond = 4'b1000; annul = 1'b0; pc = 32'h204; disp22 = 22'd16;
    #1;
    chk("dcti_err", {31'd0, dcti_err}, 32'd1);
    chk("dcti_squash", {31'd0, squash}, 32'd0);
    tick();
    br_valid = 1'b0;
    chk("dcti_no_second_taken", {31'd0, taken}, 32'd0);
    #1;
    chk("dcti_err_pulse", {31'd0, dcti_err}, 32'd0);
    slot("idle_ignores_slot", 1'b0);

    // Reset while waiting for an annulled slot
    branch("bn_a", 4'b0000, 1'b1, 32'h600, 22'd3, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_delay_icc", {28'd0, N, Z, C, V}, 32'd0);
    chk("rst_delay_taken", {31'd0, taken}, 32'd0);
    chk("rst_delay_target", target, 32'd0);
    slot("after_rst", 1'b0);

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
